// File: rtl/uart_apb_bridge.sv
// UART-to-APB bridge: decodes 8N1 command frames from rx, runs one APB
// transfer per command as bus master and returns status/read data on tx.
module uart_apb_bridge #(
    parameter int unsigned CLKS_PER_BIT = 625,
    parameter int unsigned W_ADDR       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    output logic              apbm_psel,
    output logic              apbm_penable,
    output logic              apbm_pwrite,
    output logic [W_ADDR-1:0] apbm_paddr,
    output logic [31:0]       apbm_pwdata,
    input  logic [31:0]       apbm_prdata,
    input  logic              apbm_pready,
    input  logic              apbm_pslverr,
    output logic              busy,
    output logic              frame_err
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        CMD, ADDR0, ADDR1, D0, D1, D2, D3, APB_SETUP, APB_ACCESS, RESP
    } state_t;

    logic [1:0]       rst_pipe;
    logic             rst_n_sync;
    logic             rx_meta, rx_s, rx_prev;
    rx_state_t        rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    state_t           state, state_nx;
    logic             is_write;
    logic [15:0]      addr, addr_nx;
    logic [31:0]      wdata, wdata_nx, rdata;
    logic [2:0]       resp_idx, resp_len;
    logic             tx_load, tx_busy, tx_done;
    logic [7:0]       tx_data;
    logic [9:0]       tx_shift;
    logic [3:0]       tx_bitn;
    logic [CNT_W-1:0] tx_cnt;

    // Reset synchroniser: asserts asynchronously, releases after two clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n_sync = rst_pipe[1];

    // Two-flop rx synchroniser plus one history flop for falling-edge detect
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) {rx_meta, rx_s, rx_prev} <= 3'b111;
        else             {rx_meta, rx_s, rx_prev} <= {rx, rx_meta, rx_s};
    end

    // RX next state: start validated at half bit, then 8 data bits and stop
    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_state_nx = RX_START;
            RX_START: if (rx_cnt == '0) rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == '0 && rx_bit == 3'd7) rx_state_nx = RX_STOP;
            RX_STOP:  if (rx_cnt == '0) rx_state_nx = RX_IDLE;
            default:  rx_state_nx = RX_IDLE;
        endcase
    end

    // RX state, bit timer, shift register and byte/frame-error pulses
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nx;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_state == RX_IDLE)  rx_cnt <= HALF_LAST;
            else if (rx_cnt == '0)    rx_cnt <= BIT_LAST;
            else                      rx_cnt <= rx_cnt - 1'b1;
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_cnt == '0) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == RX_STOP && rx_cnt == '0) begin
                byte_valid <= rx_s;
                frame_err  <= !rx_s;
            end
        end
    end

    assign resp_len = is_write ? 3'd1 : 3'd5;

    // Parser next state and TX load requests
    always_comb begin
        state_nx = state;
        tx_load  = 1'b0;
        tx_data  = 8'hEE;
        addr_nx  = addr;
        wdata_nx = wdata;
        case (state)
            CMD: if (byte_valid) begin
                if (rx_shift == 8'h01 || rx_shift == 8'h02) state_nx = ADDR0;
                else if (!tx_busy)                          tx_load  = 1'b1;
            end
            ADDR0: if (byte_valid) begin
                addr_nx[7:0] = rx_shift;
                state_nx     = ADDR1;
            end
            ADDR1: if (byte_valid) begin
                addr_nx[15:8] = rx_shift;
                state_nx      = is_write ? D0 : APB_SETUP;
            end
            D0: if (byte_valid) begin wdata_nx[7:0]   = rx_shift; state_nx = D1; end
            D1: if (byte_valid) begin wdata_nx[15:8]  = rx_shift; state_nx = D2; end
            D2: if (byte_valid) begin wdata_nx[23:16] = rx_shift; state_nx = D3; end
            D3: if (byte_valid) begin wdata_nx[31:24] = rx_shift; state_nx = APB_SETUP; end
            APB_SETUP: state_nx = APB_ACCESS;
            APB_ACCESS: if (apbm_pready) begin
                state_nx = RESP;
                tx_load  = 1'b1;
                tx_data  = {7'b0, apbm_pslverr};
            end
            RESP: if (tx_done) begin
                if (resp_idx < resp_len) begin
                    tx_load = 1'b1;
                    case (resp_idx)
                        3'd1:    tx_data = rdata[7:0];
                        3'd2:    tx_data = rdata[15:8];
                        3'd3:    tx_data = rdata[23:16];
                        default: tx_data = rdata[31:24];
                    endcase
                end else begin
                    state_nx = CMD;
                end
            end
            default: state_nx = CMD;
        endcase
        // A bad stop bit abandons a half-received command; bus/response phases run to completion
        if (frame_err && state != APB_SETUP && state != APB_ACCESS && state != RESP)
            state_nx = CMD;
    end

    // Parser registers; APB address/data latch on entry to SETUP and then hold
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state       <= CMD;
            is_write    <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rdata       <= '0;
            resp_idx    <= '0;
            apbm_pwrite <= 1'b0;
            apbm_paddr  <= '0;
            apbm_pwdata <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            wdata <= wdata_nx;
            if (state == CMD && byte_valid) is_write <= (rx_shift == 8'h02);
            if (state_nx == APB_SETUP) begin
                apbm_paddr  <= W_ADDR'(addr_nx);
                apbm_pwrite <= is_write;
                if (is_write) apbm_pwdata <= wdata_nx;
            end
            if (state == APB_ACCESS && apbm_pready) begin
                rdata    <= apbm_prdata;
                resp_idx <= 3'd1;
            end else if (state == RESP && tx_load) begin
                resp_idx <= resp_idx + 1'b1;
            end
        end
    end

    assign apbm_psel    = (state == APB_SETUP) || (state == APB_ACCESS);
    assign apbm_penable = (state == APB_ACCESS);
    assign busy         = (state != CMD) || tx_busy;

    assign tx_done = tx_busy && (tx_cnt == '0) && (tx_bitn == 4'd9);
    assign tx      = tx_shift[0];

    // TX framer: start + 8 data + stop; a load on tx_done chains frames with no gap
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            tx_shift <= '1;
            tx_bitn  <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
        end else if (tx_load) begin
            tx_shift <= {1'b1, tx_data, 1'b0};
            tx_bitn  <= '0;
            tx_cnt   <= BIT_LAST;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == '0) begin
                tx_cnt   <= BIT_LAST;
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bitn  <= tx_bitn + 1'b1;
                if (tx_bitn == 4'd9) tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end
endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- UART-to-APB initiator: receives framed command bytes on a UART line and executes APB read/write transfers as bus master. Returns status and read data on the UART TX line.
- Debug/bring-up host port: lets a PC poke any APB peripheral, including uart_regs, without a CPU.
- Byte format fixed: 8N1, LSB first. Integer clock divider, no FIFOs.

Parameters:
- CLKS_PER_BIT, 625, clk cycles per UART bit (72 MHz / 115200); must be >= 8.
- W_ADDR, 16, APB address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset, synchronised internally through reset_sync (2 cycles)
- rx  in  1  UART receive line, asynchronous, idle high
- tx  out  1  UART transmit line, idle high
- apbm_psel  out  1  APB select
- apbm_penable  out  1  APB enable
- apbm_pwrite  out  1  APB write
- apbm_paddr  out  W_ADDR  APB address
- apbm_pwdata  out  32  APB write data
- apbm_prdata  in  32  APB read data
- apbm_pready  in  1  APB ready
- apbm_pslverr  in  1  APB error
- busy  out  1  high whenever the parser is not in CMD state, or the APB or TX path is active
- frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset values: tx=1; all apbm_* outputs 0; busy=0; frame_err=0; parser in CMD state.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - A falling edge while RX is idle starts a bit counter. Start is resampled at CLKS_PER_BIT/2; if high, it is a glitch and RX returns to idle.
  - Data bits are sampled every CLKS_PER_BIT from the start-bit centre. Stop bit is sampled one period after bit 7.
  - Stop=1: byte_valid pulses for 1 cycle. Stop=0: frame_err pulses, the byte is dropped and the parser is forced back to CMD.
- Command protocol (multi-byte fields LSB first):
  - 0x01 = read: CMD, ADDR0, ADDR1.
  - 0x02 = write: CMD, ADDR0, ADDR1, D0, D1, D2, D3.
  - Any other CMD byte: respond single byte 0xEE, stay in CMD.
- Parser states: CMD -> ADDR0 -> ADDR1 -> (write: D0 -> D1 -> D2 -> D3) -> APB_SETUP -> APB_ACCESS -> RESP -> CMD.
- Bytes received while in APB_SETUP, APB_ACCESS or RESP are discarded silently. The host must wait for the full response.
- APB transfer:
  - APB_SETUP lasts exactly 1 cycle: psel=1, penable=0, paddr/pwrite/pwdata valid.
  - APB_ACCESS: psel=1, penable=1, held until pready=1. prdata and pslverr are captured on that edge.
  - Next cycle psel=penable=0. paddr/pwdata hold their last values. No timeout; wait states are unbounded.
- Response:
  - Status byte 0x00 = OK, 0x01 = pslverr.
  - Read: status then prdata bytes 0..3, always sent even on error.
  - Write: status only.
  - First start bit begins the cycle after leaving APB_ACCESS. Bytes are sent back-to-back with exactly one stop bit, no idle gap.
  - Return to CMD after the last stop bit completes.
- TX: own bit counter reloaded with CLKS_PER_BIT-1 per bit. The 0xEE response uses the same TX path.
- Reset mid-operation: async reset aborts any state. tx goes high and psel drops immediately, even mid APB_ACCESS.
- Address above W_ADDR bits: ADDR1 supplies bits [15:8]. If W_ADDR<16, excess bits are ignored.

Test Plan:
- Write: host sends 02 10 00 EF BE AD DE, slave pready=1 -> one APB write, paddr=0x0010, pwdata=0xDEADBEEF, SETUP then ACCESS each 1 cycle; tx returns 00.
- Read with 3 wait states: send 01 04 00, slave returns prdata=0x12345678 after pready low for 3 cycles -> penable held 4 cycles; tx returns 00 78 56 34 12 back-to-back.
- Error: read with pslverr=1, prdata=0 -> tx returns 01 00 00 00 00. Write with pslverr=1 -> tx returns 01.
- Bad command 0x55 -> no APB activity, tx returns EE. A following valid read executes normally.
- Framing error: stop bit driven low on ADDR0 -> frame_err pulse, parser back to CMD. Next 01 00 00 gives a correct read with paddr=0x0000.
- Glitch and reset: rx low pulse of CLKS_PER_BIT/4 -> no byte decoded. Assert rst_n during APB_ACCESS -> psel=penable=0 and tx=1 asynchronously; busy=0 after release.
